// File: rtl/mac_lane_engine_if.sv
// Bus bundle for the MAC lane engine: job control, coefficient ROM port,
// sample-vector handshake and SRAM write port.
interface mac_lane_engine_if #(
    parameter int LANES  = 4,
    parameter int X_W    = 8,
    parameter int A_W    = 14,
    parameter int ROM_AW = 4,
    parameter int RAM_AW = 8,
    parameter int RAM_DW = 32
) ();
    logic                    start;
    logic                    wr_ptr_clr;
    logic                    busy;
    logic                    done;
    logic [ROM_AW-1:0]       rom_addr;
    logic [A_W-1:0]          a_data;
    logic [LANES*X_W-1:0]    x_data;
    logic                    x_valid;
    logic                    x_ready;
    logic                    ram_we_n;
    logic [RAM_AW-1:0]       ram_addr;
    logic [RAM_DW-1:0]       ram_wdata;
    logic [LANES-1:0]        sat;

    // engine side
    modport slave (
        input  start, wr_ptr_clr, a_data, x_data, x_valid,
        output busy, done, rom_addr, x_ready, ram_we_n, ram_addr, ram_wdata, sat
    );

    // controller / memory side
    modport master (
        output start, wr_ptr_clr, a_data, x_data, x_valid,
        input  busy, done, rom_addr, x_ready, ram_we_n, ram_addr, ram_wdata, sat
    );
endinterface

// File: rtl/mac_lane_engine.sv
// LANES-wide multiply-accumulate engine. Each job accumulates TERMS
// coefficient*sample products per lane, clamps to ACC_W bits and writes the
// results one lane per cycle to SRAM at a persistent, wrapping pointer.
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  IDLE   | waiting for start; wr_ptr_clr honoured here
//  RD     | rom_addr = term index, ROM data arrives next cycle
//  MAC    | x_ready high; accumulate on x_valid, otherwise stall
//  SAT    | clamp accumulators, update sticky sat flags
//  WR     | one lane per cycle onto the SRAM write port
//  DONE   | one-cycle done pulse
module mac_lane_engine #(
    parameter int LANES  = 4,
    parameter int X_W    = 8,
    parameter int A_W    = 14,
    parameter int ACC_W  = 18,
    parameter int TERMS  = 8,
    parameter int ROM_AW = 4,
    parameter int RAM_AW = 8,
    parameter int RAM_DW = 32,
    parameter bit SIGNED = 1'b1
) (
    input logic               clk,
    input logic               rst,
    mac_lane_engine_if.slave  bus
);
    // Accumulator is wide enough that TERMS full-scale products never wrap.
    localparam int AW = X_W + A_W + $clog2(TERMS) + 1;
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [ROM_AW-1:0] K_LAST = ROM_AW'(TERMS - 1);
    localparam logic [LW-1:0]     J_LAST = LW'(LANES - 1);

    localparam logic signed [AW-1:0] S_MAX = {{(AW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [AW-1:0] S_MIN = {{(AW-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
    localparam logic signed [AW-1:0] U_MAX = {{(AW-ACC_W){1'b0}}, {ACC_W{1'b1}}};

    typedef enum logic [2:0] {S_IDLE, S_RD, S_MAC, S_SAT, S_WR, S_DONE} state_t;

    state_t                  state;
    logic [ROM_AW-1:0]       k;
    logic [LW-1:0]           j;
    logic [RAM_AW-1:0]       ptr;
    logic [A_W-1:0]          a_lat;
    logic                    a_first;
    logic signed [AW-1:0]    acc [LANES];
    logic [ACC_W-1:0]        res [LANES];

    logic [A_W-1:0]          a_use;
    logic signed [AW-1:0]    prod [LANES];
    logic [ACC_W-1:0]        res_c [LANES];
    logic [LANES-1:0]        clip_c;

    function automatic logic signed [AW-1:0] widen_x(input logic [X_W-1:0] v);
        if (SIGNED) widen_x = AW'($signed(v));
        else        widen_x = AW'(v);
    endfunction

    function automatic logic signed [AW-1:0] widen_a(input logic [A_W-1:0] v);
        if (SIGNED) widen_a = AW'($signed(v));
        else        widen_a = AW'(v);
    endfunction

    function automatic logic [RAM_DW-1:0] ext_res(input logic [ACC_W-1:0] v);
        if (SIGNED) ext_res = RAM_DW'($signed(v));
        else        ext_res = RAM_DW'(v);
    endfunction

    // Per-lane products; the ROM word is used live on the first MAC cycle and
    // from the latch while stalled.
    always_comb begin
        a_use = a_first ? bus.a_data : a_lat;
        for (int i = 0; i < LANES; i++) begin
            prod[i] = widen_x(bus.x_data[i*X_W +: X_W]) * widen_a(a_use);
        end
    end

    // Clamp each accumulator into the stored result range.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            clip_c[i] = 1'b0;
            res_c[i]  = acc[i][ACC_W-1:0];
            if (SIGNED) begin
                if (acc[i] > S_MAX) begin
                    res_c[i]  = S_MAX[ACC_W-1:0];
                    clip_c[i] = 1'b1;
                end else if (acc[i] < S_MIN) begin
                    res_c[i]  = S_MIN[ACC_W-1:0];
                    clip_c[i] = 1'b1;
                end
            end else if (acc[i] > U_MAX) begin
                res_c[i]  = U_MAX[ACC_W-1:0];
                clip_c[i] = 1'b1;
            end
        end
    end

    // Job sequencer with registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            k             <= '0;
            j             <= '0;
            ptr           <= '0;
            a_lat         <= '0;
            a_first       <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.x_ready   <= 1'b0;
            bus.ram_we_n  <= 1'b1;
            bus.rom_addr  <= '0;
            bus.ram_addr  <= '0;
            bus.ram_wdata <= '0;
            bus.sat       <= '0;
            for (int i = 0; i < LANES; i++) begin
                acc[i] <= '0;
                res[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.wr_ptr_clr) ptr <= '0;
                    if (bus.start) begin
                        state        <= S_RD;
                        bus.busy     <= 1'b1;
                        k            <= '0;
                        bus.rom_addr <= '0;
                        bus.sat      <= '0;
                        for (int i = 0; i < LANES; i++) acc[i] <= '0;
                    end
                end
                S_RD: begin
                    state       <= S_MAC;
                    bus.x_ready <= 1'b1;
                    a_first     <= 1'b1;
                end
                S_MAC: begin
                    if (a_first) begin
                        a_lat   <= bus.a_data;
                        a_first <= 1'b0;
                    end
                    if (bus.x_valid) begin
                        bus.x_ready <= 1'b0;
                        for (int i = 0; i < LANES; i++) acc[i] <= acc[i] + prod[i];
                        if (k == K_LAST) begin
                            state <= S_SAT;
                        end else begin
                            k            <= k + 1'b1;
                            bus.rom_addr <= k + 1'b1;
                            state        <= S_RD;
                        end
                    end
                end
                S_SAT: begin
                    for (int i = 0; i < LANES; i++) res[i] <= res_c[i];
                    bus.sat       <= bus.sat | clip_c;
                    state         <= S_WR;
                    j             <= '0;
                    bus.ram_we_n  <= 1'b0;
                    bus.ram_addr  <= ptr;
                    bus.ram_wdata <= ext_res(res_c[0]);
                    ptr           <= ptr + 1'b1;
                end
                S_WR: begin
                    if (j == J_LAST) begin
                        bus.ram_we_n <= 1'b1;
                        bus.done     <= 1'b1;
                        state        <= S_DONE;
                    end else begin
                        j             <= j + 1'b1;
                        bus.ram_addr  <= ptr;
                        bus.ram_wdata <= ext_res(res[j + 1'b1]);
                        ptr           <= ptr + 1'b1;
                    end
                end
                S_DONE: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mac_lane_engine.sv
// Bench for mac_lane_engine: an unsigned and a signed instance share stimulus;
// a job-level arithmetic model predicts every SRAM write and the sat flags.
module tb_mac_lane_engine;
    localparam int LANES  = 4;
    localparam int X_W    = 8;
    localparam int A_W    = 14;
    localparam int ACC_W  = 18;
    localparam int TERMS  = 4;
    localparam int ROM_AW = 4;
    localparam int RAM_AW = 8;
    localparam int RAM_DW = 32;
    localparam int BASE_LAT = 2*TERMS + LANES + 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst = 1'b0;
    logic                 start = 1'b0;
    logic                 wr_ptr_clr = 1'b0;
    logic                 x_valid = 1'b0;
    logic [LANES*X_W-1:0] x_data = '0;
    logic [A_W-1:0]       rom [2**ROM_AW];

    mac_lane_engine_if #(.LANES(LANES), .X_W(X_W), .A_W(A_W), .ROM_AW(ROM_AW),
                         .RAM_AW(RAM_AW), .RAM_DW(RAM_DW)) bus_u ();
    mac_lane_engine_if #(.LANES(LANES), .X_W(X_W), .A_W(A_W), .ROM_AW(ROM_AW),
                         .RAM_AW(RAM_AW), .RAM_DW(RAM_DW)) bus_s ();

    assign bus_u.start      = start;
    assign bus_u.wr_ptr_clr = wr_ptr_clr;
    assign bus_u.x_data     = x_data;
    assign bus_u.x_valid    = x_valid;
    assign bus_s.start      = start;
    assign bus_s.wr_ptr_clr = wr_ptr_clr;
    assign bus_s.x_data     = x_data;
    assign bus_s.x_valid    = x_valid;

    // synchronous coefficient ROMs
    always @(posedge clk) begin
        bus_u.a_data <= rom[bus_u.rom_addr];
        bus_s.a_data <= rom[bus_s.rom_addr];
    end

    mac_lane_engine #(.LANES(LANES), .X_W(X_W), .A_W(A_W), .ACC_W(ACC_W), .TERMS(TERMS),
                      .ROM_AW(ROM_AW), .RAM_AW(RAM_AW), .RAM_DW(RAM_DW), .SIGNED(1'b0))
        dut_u (.clk(clk), .rst(rst), .bus(bus_u.slave));

    mac_lane_engine #(.LANES(LANES), .X_W(X_W), .A_W(A_W), .ACC_W(ACC_W), .TERMS(TERMS),
                      .ROM_AW(ROM_AW), .RAM_AW(RAM_AW), .RAM_DW(RAM_DW), .SIGNED(1'b1))
        dut_s (.clk(clk), .rst(rst), .bus(bus_s.slave));

    typedef struct packed {
        logic [RAM_AW-1:0] addr;
        logic [RAM_DW-1:0] data;
    } wr_t;

    wr_t               q_u[$];
    wr_t               q_s[$];
    wr_t               e_u, e_s;
    logic [A_W-1:0]    job_a [TERMS];
    logic [X_W-1:0]    job_x [TERMS][LANES];
    logic [RAM_AW-1:0] ptr_m = '0;
    logic [LANES-1:0]  exp_sat_u = '0;
    logic [LANES-1:0]  exp_sat_s = '0;
    logic [RAM_DW-1:0] log_du [LANES];
    logic [RAM_DW-1:0] log_ds [LANES];
    logic [RAM_AW-1:0] log_au [LANES];
    int                log_nu = 0;
    int                log_ns = 0;
    int                total = 0;
    int                bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Job-level model: sum of products per lane, clamp, write list.
    function automatic void model_job();
        for (int sg = 0; sg < 2; sg++) begin
            logic [LANES-1:0] sb;
            sb = '0;
            for (int i = 0; i < LANES; i++) begin
                longint sum, lo, hi, r;
                wr_t w;
                sum = 0;
                for (int k = 0; k < TERMS; k++) begin
                    if (sg == 1) sum += longint'($signed(job_x[k][i])) * longint'($signed(job_a[k]));
                    else         sum += longint'(job_x[k][i]) * longint'(job_a[k]);
                end
                lo = (sg == 1) ? -(64'sd1 <<< (ACC_W-1)) : 64'sd0;
                hi = (sg == 1) ? (64'sd1 <<< (ACC_W-1)) - 1 : (64'sd1 <<< ACC_W) - 1;
                r = sum;
                if (sum > hi) begin r = hi; sb[i] = 1'b1; end
                else if (sum < lo) begin r = lo; sb[i] = 1'b1; end
                w.addr = ptr_m + RAM_AW'(i);
                w.data = r[RAM_DW-1:0];
                if (sg == 1) q_s.push_back(w);
                else         q_u.push_back(w);
            end
            if (sg == 1) exp_sat_s = sb;
            else         exp_sat_u = sb;
        end
        ptr_m = ptr_m + RAM_AW'(LANES);
    endfunction

    function automatic logic [LANES*X_W-1:0] pack(input int t);
        logic [LANES*X_W-1:0] v;
        v = '0;
        for (int i = 0; i < LANES; i++) v[i*X_W +: X_W] = job_x[t][i];
        return v;
    endfunction

    // every write seen on either SRAM port must be the next one predicted
    always @(negedge clk) begin
        if (rst) begin
            if (bus_u.ram_we_n === 1'b0) begin
                if (q_u.size() == 0) begin
                    total++; bad++;
                    $display("FAIL wr_extra_u: got write at addr %0d, expected none", bus_u.ram_addr);
                end else begin
                    e_u = q_u.pop_front();
                    chk("wr_addr_u", 64'(bus_u.ram_addr), 64'(e_u.addr));
                    chk("wr_data_u", 64'(bus_u.ram_wdata), 64'(e_u.data));
                end
                if (log_nu < LANES) begin
                    log_du[log_nu] = bus_u.ram_wdata;
                    log_au[log_nu] = bus_u.ram_addr;
                end
                log_nu++;
            end
            if (bus_s.ram_we_n === 1'b0) begin
                if (q_s.size() == 0) begin
                    total++; bad++;
                    $display("FAIL wr_extra_s: got write at addr %0d, expected none", bus_s.ram_addr);
                end else begin
                    e_s = q_s.pop_front();
                    chk("wr_addr_s", 64'(bus_s.ram_addr), 64'(e_s.addr));
                    chk("wr_data_s", 64'(bus_s.ram_wdata), 64'(e_s.data));
                end
                if (log_ns < LANES) log_ds[log_ns] = bus_s.ram_wdata;
                log_ns++;
            end
        end
    end

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"},     64'(bus_u.busy),      64'd0);
        chk({tag, "_done"},     64'(bus_u.done),      64'd0);
        chk({tag, "_x_ready"},  64'(bus_u.x_ready),   64'd0);
        chk({tag, "_ram_we_n"}, 64'(bus_u.ram_we_n),  64'd1);
        chk({tag, "_rom_addr"}, 64'(bus_u.rom_addr),  64'd0);
        chk({tag, "_ram_addr"}, 64'(bus_u.ram_addr),  64'd0);
        chk({tag, "_wdata"},    64'(bus_u.ram_wdata), 64'd0);
        chk({tag, "_sat_u"},    64'(bus_u.sat),       64'd0);
        chk({tag, "_sat_s"},    64'(bus_s.sat),       64'd0);
        chk({tag, "_busy_s"},   64'(bus_s.busy),      64'd0);
    endtask

    // mode 0: x_valid always high, 1: 5-cycle stall in term 2,
    // 2: random x_valid plus a spurious start while busy, 3: reset in term 2
    task automatic run_job(input int mode, input bit clr, output int lat);
        int c, term, stalls, stall_left, spurious;
        bit fire, done_seen, aborted;
        @(posedge clk); #1;
        for (int k = 0; k < TERMS; k++) rom[k] = job_a[k];
        if (clr) ptr_m = '0;
        if (mode != 3) model_job();
        log_nu = 0;
        log_ns = 0;
        start = 1'b1;
        wr_ptr_clr = clr;
        x_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        wr_ptr_clr = 1'b0;
        c = 1; term = 0; stalls = 0; stall_left = 5; lat = -1;
        done_seen = 1'b0; aborted = 1'b0;
        spurious = $urandom_range(10, 2);
        while (!done_seen && !aborted && c < 400) begin
            x_data = (term < TERMS) ? pack(term) : (LANES*X_W)'($urandom);
            x_valid = 1'b1;
            if (mode == 1 && term == 2 && bus_u.x_ready === 1'b1 && stall_left > 0) begin
                x_valid = 1'b0;
                stall_left--;
            end
            if (mode == 2) begin
                x_valid = ($urandom_range(2, 0) != 0);
                start = (c == spurious);
            end
            if (mode == 3 && term == 2 && bus_u.x_ready === 1'b1) begin
                rst = 1'b0;
                @(negedge clk);
                chk_idle_outputs("rst_mid");
                @(posedge clk);
                @(posedge clk); #1;
                rst = 1'b1;
                ptr_m = '0;
                aborted = 1'b1;
            end else begin
                @(negedge clk);
                if (bus_u.done === 1'b1) begin
                    done_seen = 1'b1;
                    lat = c;
                end
                if (bus_u.x_ready === 1'b1 && !x_valid) stalls++;
                fire = (bus_u.x_ready === 1'b1) && x_valid;
                @(posedge clk); #1;
                c++;
                start = 1'b0;
                if (fire) term++;
            end
        end
        x_valid = 1'b0;
        if (mode == 3) begin
            if (!aborted) begin
                total++; bad++;
                $display("FAIL rst_trigger: got no term-2 MAC within %0d cycles, expected one", c);
            end
        end else if (!done_seen) begin
            total++; bad++;
            $display("FAIL job_timeout: got no done within %0d cycles, expected done", c);
        end else begin
            chk("latency",      64'(lat), 64'(BASE_LAT + stalls));
            chk("sat_u",        64'(bus_u.sat), 64'(exp_sat_u));
            chk("sat_s",        64'(bus_s.sat), 64'(exp_sat_s));
            chk("pending_u",    64'(q_u.size()), 64'd0);
            chk("pending_s",    64'(q_s.size()), 64'd0);
            @(negedge clk);
            chk("idle_after_done", 64'(bus_u.busy), 64'd0);
        end
    endtask

    task automatic set_job_a();
        for (int k = 0; k < TERMS; k++) begin
            job_a[k] = A_W'(k + 1);
            for (int i = 0; i < LANES; i++) job_x[k][i] = X_W'(i + 1);
        end
    endtask

    task automatic set_job_const(input logic [X_W-1:0] xv, input logic [A_W-1:0] av);
        for (int k = 0; k < TERMS; k++) begin
            job_a[k] = av;
            for (int i = 0; i < LANES; i++) job_x[k][i] = xv;
        end
    endtask

    task automatic set_job_rand();
        for (int k = 0; k < TERMS; k++) begin
            job_a[k] = ($urandom_range(1, 0) == 1) ? A_W'($urandom) : A_W'($urandom_range(255, 0));
            for (int i = 0; i < LANES; i++) job_x[k][i] = X_W'($urandom);
        end
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1;
        wr_ptr_clr = 1'b1;
        ptr_m = '0;
        @(posedge clk); #1;
        wr_ptr_clr = 1'b0;
    endtask

    task automatic chk_basic_block(input string tag, input int base);
        chk({tag, "_count"}, 64'(log_nu), 64'(LANES));
        for (int i = 0; i < LANES; i++) begin
            chk({tag, "_data_u"}, 64'(log_du[i]), 64'(10 * (i + 1)));
            chk({tag, "_data_s"}, 64'(log_ds[i]), 64'(10 * (i + 1)));
            chk({tag, "_addr"},   64'(log_au[i]), 64'(base + i));
        end
    endtask

    initial begin
        int lat;
        for (int i = 0; i < 2**ROM_AW; i++) rom[i] = '0;

        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b1;

        set_job_a();
        run_job(0, 1'b0, lat);
        chk("lat_basic", 64'(lat), 64'd14);
        chk_basic_block("basic", 0);

        run_job(1, 1'b0, lat);
        chk("lat_stall", 64'(lat), 64'd19);
        chk_basic_block("stall", 4);

        set_job_const(8'd127, 14'd8191);
        run_job(0, 1'b0, lat);
        for (int i = 0; i < LANES; i++) begin
            chk("satpos_s", 64'(log_ds[i]), 64'h0001FFFF);
            chk("satpos_u", 64'(log_du[i]), 64'h0003FFFF);
        end
        chk("satpos_flags", 64'(bus_s.sat), 64'hF);

        set_job_const(8'h80, 14'd8191);
        run_job(0, 1'b0, lat);
        for (int i = 0; i < LANES; i++) chk("satneg_s", 64'(log_ds[i]), 64'hFFFE0000);
        chk("satneg_flags", 64'(bus_s.sat), 64'hF);

        repeat (24) begin
            set_job_rand();
            run_job(2, ($urandom_range(3, 0) == 0), lat);
        end

        pulse_clr();
        set_job_a();
        run_job(0, 1'b0, lat);
        chk_basic_block("clr", 0);

        pulse_clr();
        for (int jb = 1; jb <= 65; jb++) begin
            set_job_rand();
            run_job(0, 1'b0, lat);
            if (jb == 64) chk("wrap_top", 64'(log_au[LANES-1]), 64'd255);
        end
        chk("wrap_restart", 64'(log_au[0]), 64'd0);

        set_job_a();
        run_job(3, 1'b0, lat);
        set_job_a();
        run_job(0, 1'b0, lat);
        chk_basic_block("post_rst", 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
